axis_frame_packetizer: RTL and testbench
========================================

// Module: axis_frame_packetizer
// PURPOSE
//  Downstream stage of the ADC-to-AXIS converter. Consumes its continuous sample stream,
//  cuts it into fixed-length frames, prepends one header beat per frame carrying a sequence
//  number, and drives tlast on the final payload beat. Output feeds DMA/interconnect.
//  Full throughput with registered outputs via an output skid buffer.
// PARAMETERS
//  DATA_WIDTH  32    beat width, >= 32 (header layout needs 32 bits)
//  FRAME_LEN   256   payload beats per frame, >= 2
//  HDR_MAGIC   16'hA5A5  constant in header bits [31:16]
// PORTS
//  axis_aclk        in   1           single clock, shared by both AXIS sides
//  axis_aresetn     in   1           synchronous, active-low reset
//  s_axis_tvalid    in   1           sample valid from converter
//  s_axis_tdata     in   DATA_WIDTH  sample data
//  s_axis_tready    out  1           sample accepted when tvalid&tready
//  m_axis_tvalid    out  1           framed stream valid
//  m_axis_tdata     out  DATA_WIDTH  header or payload
//  m_axis_tlast     out  1           1 on last payload beat of frame
//  m_axis_tready    in   1           downstream ready
//  i_enable         in   1           1: produce frames; 0: stop at next frame boundary
//  o_frame_seq      out  16          sequence number of next header to be sent
//  o_busy           out  1           1 while FSM not IDLE
// BEHAVIOUR
//  Reset (sync, aresetn=0 at clock edge): all outputs 0, FSM=IDLE, seq=0, beat_cnt=0,
//   skid buffer emptied. Reset mid-frame discards partial frame; no tlast is emitted.
//  FSM states: IDLE, HEADER, PAYLOAD.
//   IDLE:    s_axis_tready=0. i_enable=1 -> HEADER next cycle.
//   HEADER:  push one internal beat {HDR_MAGIC, seq[15:0]}, upper bits zero if
//            DATA_WIDTH>32; no input consumed. On push -> PAYLOAD, beat_cnt=0.
//   PAYLOAD: s_axis_tready = skid can accept; each accepted input beat is pushed with
//            tlast=(beat_cnt==FRAME_LEN-1), beat_cnt++. On the last push: seq++ (16-bit wrap
//            FFFF->0000), beat_cnt=0, -> HEADER if i_enable else IDLE.
//  i_enable sampled only in IDLE and on the last payload beat; deassertion mid-frame
//   never truncates a frame.
//  Skid buffer: 2-entry (main + skid reg). Upstream ready = !skid_full, registered.
//   Main register drives m_axis_*. m_axis_tdata/tlast stable while tvalid&!tready (AXIS rule).
//  Latency: accepted input beat appears on m_axis 1 cycle later when output empty.
//  Throughput: with s_axis_tvalid and m_axis_tready held 1, one frame = FRAME_LEN+1
//   cycles, no bubbles between frames.
//  Backpressure: m_axis_tready=0 fills skid within 1 cycle, then s_axis_tready=0;
//   no beat lost or duplicated. Simultaneous push and pop on a full main reg passes
//   through without stall.
//  s_axis_tvalid gaps inside PAYLOAD: FSM waits, beat_cnt holds, no filler beats.
//  o_frame_seq updates the cycle after the last payload push.
//  o_busy = (state != IDLE) | m_axis_tvalid.
// STRUCTURE
//  Shared package: state encoding (IDLE/HEADER/PAYLOAD), HDR_MAGIC default,
//   header field offsets (SEQ_LSB=0, MAGIC_LSB=16).
//  Sub-module: axis_skid_buffer #(DATA_WIDTH+1) (tdata+tlast), generic, reusable.
//  Top: FSM, beat counter ($clog2(FRAME_LEN) bits), seq counter, header mux.
// TESTING
//  1 FRAME_LEN=4, enable=1, src/sink always ready, data 1,2,3,... -> A5A50000,1,2,3,4(tlast),
//    A5A50001,5,6,7,8(tlast); 5 cycles/frame, no gaps.
//  2 Sink ready toggling 1010..., random src valid -> output equals header+payload model
//    exactly, tdata/tlast stable while stalled, no loss or duplication.
//  3 Drop i_enable after 2nd payload beat -> frame completes with tlast on beat 4,
//    FSM returns IDLE, s_axis_tready=0, o_frame_seq=1.
//  4 Preload seq=FFFF (run 65535 frames, FRAME_LEN=2) -> header A5A5FFFF then A5A50000.
//  5 Assert aresetn=0 for 1 cycle mid-PAYLOAD -> next cycle all outputs 0; after release
//    next frame header is A5A50000, no stray tlast.
//  6 m_axis_tready=0 for 10 cycles during PAYLOAD -> s_axis_tready falls within 2 cycles,
//    at most 2 beats buffered, resumes in order on release.

Source files
------------

// File: rtl/axis_frame_packetizer_pkg.sv
// Shared definitions for the AXI-Stream frame packetizer: FSM encoding, header layout and
// a header builder.
package axis_frame_packetizer_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StHeader  = 2'd1,
    StPayload = 2'd2
  } pkt_state_e;

  localparam logic [15:0] HdrMagicDefault = 16'hA5A5;

  // Header field offsets inside the low 32 bits of the header beat.
  localparam int unsigned SeqLsb   = 0;
  localparam int unsigned MagicLsb = 16;

  function automatic logic [31:0] make_header(input logic [15:0] magic,
                                              input logic [15:0] seq);
    logic [31:0] hdr;
    hdr                 = '0;
    hdr[MagicLsb +: 16] = magic;
    hdr[SeqLsb +: 16]   = seq;
    return hdr;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Generic two-entry AXI-Stream register slice: registered outputs and a registered upstream
// ready, full throughput.
module axis_skid_buffer #(
  parameter int unsigned Width = 33
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  input  logic             out_ready_i
);

  logic             main_valid_q, main_valid_d;
  logic [Width-1:0] main_data_q, main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] skid_data_q, skid_data_d;
  logic             push, pop;

  assign in_ready_o  = ~skid_valid_q;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = main_valid_q & out_ready_i;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!main_valid_q || pop) begin
      // Main slot frees up: refill from skid first to keep ordering.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = push;
        if (push) begin
          main_data_d = in_data_i;
        end
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/axis_frame_packetizer.sv
// Cuts a continuous sample stream into FRAME_LEN-beat frames, each preceded by a
// {magic, sequence} header beat, with tlast on the final payload beat.
module axis_frame_packetizer
  import axis_frame_packetizer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAME_LEN  = 256,
  parameter logic [15:0] HDR_MAGIC  = HdrMagicDefault
) (
  input  logic                  axis_aclk,
  input  logic                  axis_aresetn,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  input  logic                  i_enable,
  output logic [15:0]           o_frame_seq,
  output logic                  o_busy
);

  localparam int unsigned CntW = $clog2(FRAME_LEN);
  localparam logic [CntW-1:0] LastBeat = CntW'(FRAME_LEN - 1);

  pkt_state_e            state_q;
  logic [CntW-1:0]       beat_cnt_q;
  logic [15:0]           seq_q;

  logic                  push_valid;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  push_last;
  logic                  push;
  logic                  skid_ready;
  logic [DATA_WIDTH-1:0] hdr_word;

  assign hdr_word = DATA_WIDTH'(make_header(HDR_MAGIC, seq_q));

  always_comb begin
    push_valid = 1'b0;
    push_data  = '0;
    push_last  = 1'b0;
    case (state_q)
      StHeader: begin
        push_valid = 1'b1;
        push_data  = hdr_word;
      end
      StPayload: begin
        push_valid = s_axis_tvalid;
        push_data  = s_axis_tdata;
        push_last  = (beat_cnt_q == LastBeat);
      end
      default: ;
    endcase
  end

  assign push          = push_valid & skid_ready;
  assign s_axis_tready = (state_q == StPayload) & skid_ready;

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      seq_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_enable) begin
            state_q <= StHeader;
          end
        end
        StHeader: begin
          if (push) begin
            state_q    <= StPayload;
            beat_cnt_q <= '0;
          end
        end
        StPayload: begin
          if (push) begin
            if (push_last) begin
              // Enable is only looked at here so a frame is never truncated.
              seq_q      <= seq_q + 16'd1;
              beat_cnt_q <= '0;
              state_q    <= i_enable ? StHeader : StIdle;
            end else begin
              beat_cnt_q <= beat_cnt_q + CntW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  axis_skid_buffer #(
    .Width(DATA_WIDTH + 1)
  ) u_skid (
    .clk_i      (axis_aclk),
    .rst_ni     (axis_aresetn),
    .in_valid_i (push_valid),
    .in_data_i  ({push_last, push_data}),
    .in_ready_o (skid_ready),
    .out_valid_o(m_axis_tvalid),
    .out_data_o ({m_axis_tlast, m_axis_tdata}),
    .out_ready_i(m_axis_tready)
  );

  assign o_frame_seq = seq_q;
  assign o_busy      = (state_q != StIdle) | m_axis_tvalid;

endmodule

// File: tb/tb_axis_frame_packetizer.sv
// Randomized scoreboard bench for axis_frame_packetizer: a frame-level model turns accepted
// samples into expected header/payload beats that a monitor compares against the output.
module tb_axis_frame_packetizer;

  localparam int unsigned DW = 32;
  localparam int          FL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_tvalid = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tready;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tready = 1'b0;
  logic          enable = 1'b0;
  logic [15:0]   frame_seq;
  logic          busy;

  always #5 clk = ~clk;

  axis_frame_packetizer #(
    .DATA_WIDTH(DW),
    .FRAME_LEN (FL),
    .HDR_MAGIC (16'hA5A5)
  ) dut (
    .axis_aclk    (clk),
    .axis_aresetn (rst_n),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tdata (s_tdata),
    .s_axis_tready(s_tready),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tdata (m_tdata),
    .m_axis_tlast (m_tlast),
    .m_axis_tready(m_tready),
    .i_enable     (enable),
    .o_frame_seq  (frame_seq),
    .o_busy       (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Frame model: position inside the current frame and next header sequence.
  int          m_k = 0;
  logic [15:0] m_seq = '0;
  logic [DW:0] exp_q[$];
  logic [DW:0] obs_q[$];
  logic [DW:0] e_beat, o_beat, prev_beat;
  bit          prev_stall = 1'b0;

  int acc_cnt = 0;
  bit src_adv = 1'b0;
  int src_prob = 100;
  int sink_mode = 0;
  bit seq_data = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Input side: every accepted sample extends the expected frame stream.
  always @(negedge clk) begin
    if (rst_n && s_tvalid && s_tready) begin
      if (m_k == 0) exp_q.push_back({1'b0, DW'({16'hA5A5, m_seq})});
      exp_q.push_back({(m_k == FL - 1), s_tdata});
      m_k++;
      if (m_k == FL) begin
        m_k = 0;
        m_seq++;
      end
      acc_cnt++;
      src_adv = 1'b1;
    end
  end

  // Output side: collect delivered beats, check stability under backpressure.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", 64'({m_tvalid, m_tlast, m_tdata}), 64'({1'b1, prev_beat}));
      if (m_tvalid && m_tready) obs_q.push_back({m_tlast, m_tdata});
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tlast, m_tdata};
    end
  end

  always @(negedge clk) begin
    #1;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_beat = exp_q.pop_front();
      o_beat = obs_q.pop_front();
      check("beat", 64'(o_beat), 64'(e_beat));
    end
    if (!rst_n) begin
      exp_q.delete();
      obs_q.delete();
      m_k   = 0;
      m_seq = '0;
    end
  end

  task automatic cyc();
    bit adv;
    @(posedge clk);
    #1;
    case (sink_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      2:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b0;
    endcase
    adv = src_adv;
    if (adv) begin
      s_tdata = seq_data ? s_tdata + 1 : DW'($urandom);
      src_adv = 1'b0;
    end
    if (!(s_tvalid && !adv)) s_tvalid = (int'($urandom_range(1, 100)) <= src_prob);
  endtask

  task automatic do_reset(input bit chk);
    rst_n  = 1'b0;
    enable = 1'b0;
    cyc();
    if (chk) check("reset_out", 64'({m_tvalid, m_tlast, m_tdata, s_tready, busy, frame_seq}), 64'(0));
    rst_n = 1'b1;
  endtask

  task automatic drain();
    enable    = 1'b0;
    src_prob  = 100;
    sink_mode = 0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (!busy) break;
    end
    check("drain_idle", 64'(busy), 64'(0));
    cyc();
    cyc();
    check("drain_empty", 64'(exp_q.size() + obs_q.size()), 64'(0));
    check("frame_seq", 64'(frame_seq), 64'(m_seq));
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      if (m_tvalid) break;
      cyc();
    end
    check("wait_valid", 64'(m_tvalid), 64'(1));
  endtask

  task automatic wait_mid_payload();
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (m_k >= 2) break;
    end
  endtask

  initial begin
    int          base;
    int          fell_at;
    logic [DW:0] t1_exp;

    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          base;
    int          fell_at;
    logic [DW:0] t1_exp;

    sink_mode = 0;
    do_reset(1'b1);

    // Two back-to-back frames of counting data with no gaps.
    seq_data = 1'b1;
    s_tdata  = DW'(1);
    src_prob = 100;
    enable   = 1'b1;
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 0) t1_exp = {1'b0, DW'({16'hA5A5, 16'(i / 5)})};
      else            t1_exp = {(i % 5 == 4), DW'((i / 5) * 4 + (i % 5))};
      check("t1_beat", 64'({m_tvalid, m_tlast, m_tdata}), 64'({1'b1, t1_exp}));
      cyc();
    end
    drain();

    // Toggling sink, random source valid and data.
    seq_data  = 1'b0;
    sink_mode = 1;
    src_prob  = 70;
    enable    = 1'b1;
    for (int i = 0; i < 200; i++) cyc();
    drain();

    // Enable dropped mid-frame: frame completes, then idle.
    do_reset(1'b0);
    sink_mode = 0;
    src_prob  = 100;
    base      = acc_cnt;
    enable    = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (acc_cnt - base >= 2) break;
    end
    check("t3_accepted", 64'(acc_cnt - base), 64'(2));
    enable = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (!busy) break;
    end
    check("t3_idle", 64'(busy), 64'(0));
    check("t3_tready", 64'(s_tready), 64'(0));
    check("t3_seq", 64'(frame_seq), 64'(1));
    cyc();
    check("t3_total", 64'(acc_cnt - base), 64'(FL));

    // Sequence wrap from FFFF to 0000.
    force dut.seq_q = 16'hFFFF;
    cyc();
    release dut.seq_q;
    m_seq = 16'hFFFF;
    cyc();
    check("wrap_preload", 64'(frame_seq), 64'(16'hFFFF));
    sink_mode = 2;
    enable    = 1'b1;
    for (int i = 0; i < 40; i++) cyc();
    drain();

    // Ten cycles of sink backpressure mid-payload.
    enable = 1'b1;
    wait_mid_payload();
    sink_mode = 3;
    base      = acc_cnt;
    fell_at   = -1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (!s_tready && fell_at < 0) fell_at = i + 1;
    end
    check("t6_ready_fall", 64'(fell_at >= 1 && fell_at <= 2), 64'(1));
    check("t6_buffered", 64'(acc_cnt - base <= 2), 64'(1));
    check("t6_ready_low", 64'(s_tready), 64'(0));
    sink_mode = 0;
    for (int i = 0; i < 10; i++) cyc();
    drain();

    // Reset in the middle of a payload.
    enable = 1'b1;
    wait_mid_payload();
    do_reset(1'b1);
    enable = 1'b1;
    wait_valid();
    check("t5_header", 64'({m_tlast, m_tdata}), 64'({1'b0, 32'hA5A5_0000}));
    for (int i = 0; i < 12; i++) cyc();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
